// File: rtl/stage_sequencer.sv
// Sequences HLS sub-pipelines over ap_ctrl_hs: stage 0 once, then stages 1..N-1 for iter_count passes; outputs registered, no bubble between stages.
// Each stage's start is held until its ready is seen; busy-cycle counter is built only when STAGE_SEQ_PERF_CNT_EN is defined.
module stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int ITER_W     = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  input  logic [ITER_W-1:0]             iter_count,
  output logic                          ap_done,
  output logic                          ap_ready,
  output logic                          ap_idle,
  output logic [NUM_STAGES-1:0]         stg_start,
  input  logic [NUM_STAGES-1:0]         stg_ready,
  input  logic [NUM_STAGES-1:0]         stg_done,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic [31:0]                   perf_cycles
);

  localparam int SW = $clog2(NUM_STAGES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [ITER_W-1:0]     pass_q, pass_d;
  logic [NUM_STAGES-1:0] stg_start_q, stg_start_d;
  logic                  ap_idle_q, ap_idle_d;
  logic                  ap_done_q, ap_done_d;

  logic [NUM_STAGES-1:0] stage_sel;
  logic [NUM_STAGES-1:0] stage_sel_d;
  logic                  act_rdy;
  logic                  act_done;
  logic                  last_stage;
  logic                  advance;
  logic                  finish;
  logic [SW-1:0]         stage_next;
  logic [ITER_W-1:0]     pass_next;

  // Only the active stage's handshake bits are looked at.
  always_comb begin
    stage_sel   = '0;
    stage_sel_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_sel[i]   = (stage_q == SW'(i));
      stage_sel_d[i] = (stage_d == SW'(i));
    end
  end

  assign act_rdy    = |(stg_ready & stage_sel);
  assign act_done   = |(stg_done & stage_sel);
  assign last_stage = (stage_q == SW'(NUM_STAGES - 1));

  // Pass counter only decrements on the last stage, where it is known to be >= 1.
  always_comb begin
    pass_next  = pass_q;
    finish     = 1'b0;
    stage_next = stage_q + SW'(1);
    if (stage_q == '0) begin
      finish     = (pass_q == '0);
      stage_next = SW'(1);
    end else if (last_stage) begin
      pass_next  = pass_q - 1'b1;
      finish     = (pass_next == '0);
      stage_next = SW'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      pass_q      <= '0;
      stg_start_q <= '0;
      ap_idle_q   <= 1'b1;
      ap_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      pass_q      <= pass_d;
      stg_start_q <= stg_start_d;
      ap_idle_q   <= ap_idle_d;
      ap_done_q   <= ap_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pass_d  = pass_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          pass_d  = iter_count;
        end
      end
      S_ISSUE: begin
        if (act_done) begin
          advance = 1'b1;
        end else if (act_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (act_done) begin
          advance = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (advance) begin
      pass_d = pass_next;
      if (finish) begin
        state_d = S_DONE;
      end else begin
        state_d = S_ISSUE;
        stage_d = stage_next;
      end
    end
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    ap_idle_d   = (state_d == S_IDLE);
    ap_done_d   = (state_d == S_DONE);
    stg_start_d = '0;
    if (state_d == S_ISSUE) begin
      stg_start_d = stage_sel_d;
    end
  end

  assign ap_idle   = ap_idle_q;
  assign ap_done   = ap_done_q;
  assign ap_ready  = ap_done_q;
  assign stg_start = stg_start_q;
  assign cur_stage = stage_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] perf_q, perf_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  // DONE's own cycle is included in the captured value.
  always_comb begin
    cnt_d  = cnt_q;
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (ap_start) begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_inc;
    end
    if (state_q == S_DONE) begin
      perf_d = cnt_inc;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus queues the expected stage/done order, a monitor checks each DUT issue and done.
module tb_stage_sequencer;

  localparam int          N        = 3;
  localparam int          IW       = 8;
  localparam logic [31:0] DONE_TOK = 32'd255;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic [IW-1:0] iter_count;
  logic          ap_done;
  logic          ap_ready;
  logic          ap_idle;
  logic [N-1:0]  stg_start;
  logic [N-1:0]  stg_ready;
  logic [N-1:0]  stg_done;
  logic [1:0]    cur_stage;
  logic [31:0]   perf_cycles;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          rdy_wait[N];
  int          done_lat;
  bit          spur_en;

  always #5 ap_clk = ~ap_clk;

  stage_sequencer #(.NUM_STAGES(N), .ITER_W(IW)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .iter_count  (iter_count),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .stg_start   (stg_start),
    .stg_ready   (stg_ready),
    .stg_done    (stg_done),
    .cur_stage   (cur_stage),
    .perf_cycles (perf_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef STAGE_SEQ_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // Sub-pipeline model: ready after rdy_wait[s] cycles, done done_lat cycles after ready.
  initial begin : responder
    logic [N-1:0] prev;
    int act, rcnt, dcnt;
    bit pend;
    stg_ready = '0;
    stg_done  = '0;
    prev = '0;
    act  = -1;
    rcnt = 0;
    dcnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge ap_clk);
      stg_ready = '0;
      stg_done  = '0;
      if (stg_start != '0 && stg_start != prev) begin
        act  = int'(oh_idx(stg_start));
        rcnt = rdy_wait[act];
        pend = 1'b0;
      end
      prev = stg_start;
      if (act >= 0) begin
        if (!pend) begin
          if (rcnt == 0) begin
            stg_ready[act] = 1'b1;
            if (done_lat == 0) begin
              stg_done[act] = 1'b1;
              act = -1;
            end else begin
              pend = 1'b1;
              dcnt = done_lat;
            end
          end else begin
            rcnt--;
          end
        end else begin
          if (spur_en && act == 1 && dcnt == done_lat) stg_done[2] = 1'b1;
          dcnt--;
          if (dcnt == 0) begin
            stg_done[act] = 1'b1;
            act  = -1;
            pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [N-1:0] prev;
    logic [31:0] e;
    prev = '0;
    forever begin
      @(negedge ap_clk);
      if (stg_start != '0 && stg_start != prev) begin
        check("start_onehot", {31'd0, $onehot(stg_start)}, 32'd1);
        check("cur_stage_match", {30'd0, cur_stage}, oh_idx(stg_start));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start actual=%0d required=none", oh_idx(stg_start));
        end else begin
          e = exp_q.pop_front();
          check("stage_order", oh_idx(stg_start), e);
        end
      end
      prev = stg_start;
      if (ap_done) begin
        check("ready_with_done", {31'd0, ap_ready}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("done_order", e, DONE_TOK);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic start_run(input logic [IW-1:0] it);
    @(negedge ap_clk);
    check("idle_before_start", {31'd0, ap_idle}, 32'd1);
    ap_start   = 1'b1;
    iter_count = it;
    exp_q.push_back(32'd0);
    for (int p = 0; p < int'(it); p++) begin
      for (int s = 1; s < N; s++) exp_q.push_back(s);
    end
    exp_q.push_back(DONE_TOK);
    @(posedge ap_clk);
    #1;
    ap_start   = 1'b0;
    iter_count = ~it;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!ap_done && n < 1000);
    check({name, "_done_seen"}, {31'd0, ap_done}, 32'd1);
  endtask

  task automatic post_done(input string name, input logic [31:0] perf);
    @(negedge ap_clk);
    check({name, "_done_single"}, {31'd0, ap_done}, 32'd0);
    check({name, "_idle_after"}, {31'd0, ap_idle}, 32'd1);
    check({name, "_perf"}, perf_cycles, perf_exp(perf));
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin : stimulus
    int n, hi;
    for (int i = 0; i < N; i++) rdy_wait[i] = 0;
    done_lat   = 3;
    spur_en    = 1'b0;
    ap_rst_n   = 1'b0;
    ap_start   = 1'b1;
    iter_count = 8'd3;

    repeat (3) @(negedge ap_clk);
    check("rst_idle", {31'd0, ap_idle}, 32'd1);
    check("rst_stg_start", {29'd0, stg_start}, 32'd0);
    check("rst_done", {31'd0, ap_done}, 32'd0);
    check("rst_ready", {31'd0, ap_ready}, 32'd0);
    check("rst_cur_stage", {30'd0, cur_stage}, 32'd0);
    check("rst_perf", perf_cycles, 32'd0);
    ap_start = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("post_rst_idle", {31'd0, ap_idle}, 32'd1);
    check("post_rst_stg_start", {29'd0, stg_start}, 32'd0);

    // Order 0,1,2,1,2: 4 cycles per stage plus DONE.
    done_lat = 3;
    start_run(8'd2);
    wait_done("order");
    post_done("order", 32'd21);

    // iter_count=0 with immediate ready+done.
    done_lat = 0;
    start_run(8'd0);
    @(negedge ap_clk);
    check("it0_done_early", {31'd0, ap_done}, 32'd0);
    check("it0_stage0_active", {29'd0, stg_start}, 32'd1);
    @(negedge ap_clk);
    check("it0_done_2cyc", {31'd0, ap_done}, 32'd1);
    check("it0_ready_2cyc", {31'd0, ap_ready}, 32'd1);
    post_done("it0", 32'd2);

    // Stage 1 ready withheld 5 cycles.
    done_lat    = 2;
    rdy_wait[1] = 5;
    start_run(8'd1);
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!stg_start[1] && n < 200);
    hi = 0;
    while (stg_start[1] && hi < 50) begin
      hi++;
      @(negedge ap_clk);
    end
    check("dly_start1_cycles", hi, 32'd6);
    check("dly_wait_stage", {30'd0, cur_stage}, 32'd1);
    check("dly_start_low", {29'd0, stg_start}, 32'd0);
    wait_done("dly");
    post_done("dly", 32'd15);
    rdy_wait[1] = 0;

    // Spurious stg_done[2] during stage 1 WAIT.
    done_lat = 3;
    spur_en  = 1'b1;
    start_run(8'd1);
    wait_done("spur");
    post_done("spur", 32'd13);
    spur_en = 1'b0;

    // Reset during stage 2 WAIT; the stage's late done arrives while idle.
    done_lat = 3;
    start_run(8'd2);
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!(cur_stage == 2'd2 && stg_start == '0 && !ap_idle) && n < 200);
    check("mid_reached_wait2", {30'd0, cur_stage}, 32'd2);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_idle", {31'd0, ap_idle}, 32'd1);
    check("mid_rst_stg_start", {29'd0, stg_start}, 32'd0);
    check("mid_rst_cur_stage", {30'd0, cur_stage}, 32'd0);
    check("mid_rst_done", {31'd0, ap_done}, 32'd0);
    check("mid_rst_perf", perf_cycles, 32'd0);
    exp_q.delete();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      check("mid_stay_idle", {31'd0, ap_idle}, 32'd1);
      check("mid_no_start", {29'd0, stg_start}, 32'd0);
    end
    done_lat = 0;
    start_run(8'd1);
    wait_done("fresh");
    post_done("fresh", 32'd4);

    repeat (3) @(negedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Control FSM that sequences the sub-kernel pipelines of a top-level HLS kernel using block-level ap_ctrl_hs handshakes. Stage 0 runs once per invocation. Stages 1..NUM_STAGES-1 then run as an ordered pass, and that pass is repeated `iter_count` times. The block sits between the top-level ap_ctrl_hs port and the `ap_start`/`ap_ready`/`ap_done` pins of each sub-pipeline. It replaces hand-written top FSM states and gives the dataflow monitors one clean, predictable handshake pattern per stage.

## Interface
- `NUM_STAGES`, default 3: number of sub-pipelines; minimum 2.
- `ITER_W`, default 8: width of `iter_count`.
- `ap_clk`  in  1  clock, rising edge.
- `ap_rst_n`  in  1  asynchronous active-low reset.
- `ap_start`  in  1  top-level start, level; sampled only in IDLE.
- `iter_count`  in  ITER_W  number of passes over stages 1..N-1; latched when the start is accepted.
- `ap_done`  out  1  one-cycle pulse when the invocation completes.
- `ap_ready`  out  1  one-cycle pulse, coincident with `ap_done`.
- `ap_idle`  out  1  high only in IDLE.
- `stg_start`  out  NUM_STAGES  one-hot ap_start to each sub-pipeline.
- `stg_ready`  in  NUM_STAGES  ap_ready from each sub-pipeline.
- `stg_done`  in  NUM_STAGES  ap_done pulse from each sub-pipeline.
- `cur_stage`  out  clog2(NUM_STAGES)  index of the active stage, for monitors.
- `perf_cycles`  out  32  busy-cycle count of the last completed invocation.

## Operation
- States:
  - IDLE
  - ISSUE: `stg_start[cur_stage]` high
  - WAIT: start dropped, waiting for done
  - DONE
- Reset values (asynchronous): state IDLE, `ap_idle`=1, `ap_done`=0, `ap_ready`=0, `stg_start`=0, `cur_stage`=0, pass counter 0, `perf_cycles`=0.
- IDLE:
  - `ap_start`=1 latches `iter_count` into the pass counter, sets `cur_stage`=0, and goes to ISSUE.
  - Otherwise the FSM stays in IDLE.
- ISSUE:
  - `stg_start[cur_stage]` stays high until `stg_ready[cur_stage]`=1 is sampled.
  - Ready and done sampled in the same cycle: advance directly (see next-stage rule).
  - Ready only: go to WAIT.
  - Done without ready: treat as ready+done.
- WAIT: on `stg_done[cur_stage]`=1, advance.
- Next-stage rule:
  - From stage 0: if the pass counter is 0, go to DONE; else go to stage 1.
  - From stage k<N-1: go to stage k+1.
  - From stage N-1: decrement the pass counter. If the result is 0, go to DONE; else go to stage 1.
- DONE: `ap_done`=`ap_ready`=1 for exactly one cycle, then IDLE. `ap_start` is not sampled in DONE.
- `stg_ready`/`stg_done` bits for non-active stages are ignored.
- `iter_count` changes after acceptance have no effect.
- `stg_start` is never high for more than one stage.
- Pass counter is ITER_W bits.
  - `iter_count`=0 runs stage 0 only.
  - Maximum value is 2^ITER_W-1 passes; there is no wrap.

## Timing
- All outputs are registered.
- `ap_start` sampled high at edge e0: `stg_start[0]` is high from e0 onward.
- Stage advance: ready/done sampled at edge m puts the next `stg_start` high from m. There is no bubble cycle between stages.
- `stg_start` is low in the cycle after ready is sampled.
- Final done sampled at edge m:
  - `ap_done`/`ap_ready` are high for the cycle after m.
  - `ap_idle`=1 after edge m+1.
  - A new `ap_start` is accepted at edge m+2 at the earliest.
- `ap_rst_n` asserted mid-invocation:
  - All outputs go to reset values immediately.
  - Any pending `stg_done` after deassertion is ignored (FSM is in IDLE).

## Configuration
- `STAGE_SEQ_PERF_CNT_EN` defined:
  - A 32-bit counter clears on start acceptance and increments every non-IDLE cycle, DONE included.
  - Its value is copied to `perf_cycles` on the DONE→IDLE transition.
  - The counter saturates at 2^32-1.
- Not defined: no counter is built; `perf_cycles` is tied to 0.

## Test plan
- Reset:
  - Stimulus: hold `ap_rst_n`=0.
  - Required: `ap_idle`=1, `stg_start`=0, `ap_done`=0. With `ap_start`=1 during reset, no `stg_start` is issued.
- Stage order, NUM_STAGES=3, `iter_count`=2:
  - Stimulus: each stage ready immediately, done 3 cycles later.
  - Required: `stg_start` order 0,1,2,1,2; exactly one `ap_done` pulse.
- `iter_count`=0, all stages ready+done in the first ISSUE cycle:
  - Required: only stage 0 is started.
  - Required: `ap_done` appears 2 cycles after acceptance.
  - Required: `perf_cycles`=2 with the macro defined, 0 without.
- Delayed ready:
  - Stimulus: stage 1 `stg_ready` withheld for 5 cycles.
  - Required: `stg_start[1]` stays high all 5 cycles and drops the cycle after ready.
- Spurious done:
  - Stimulus: `stg_done[2]` pulsed while stage 1 is active.
  - Required: ignored; the sequence continues unchanged.
- Reset mid-run:
  - Stimulus: drop `ap_rst_n` during stage 2 WAIT, then release.
  - Required: immediately idle. Stimulus: a fresh start with `iter_count`=1. Required: stages 0,1,2, with `perf_cycles`=4 (macro on, all stages immediate).
